// File: rtl/fp_exp_pkg.sv
// Shared types and constants for the floating-point multiplier exponent path.
// Holds the sequencer state encoding, ALU op codes and half-precision defaults.
package fp_exp_pkg;

   localparam int HP_EXP_WIDTH = 5;
   localparam int HP_BIAS      = 15;

   localparam logic ALU_OP_ADD = 1'b0;
   localparam logic ALU_OP_SUB = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      ADD,
      SUB,
      NORM,
      DONE,
      ZERO
   } state_t;

endpackage

// File: rtl/fp_exp_sequencer.sv
// Exponent-path sequencer: steps an external add/sub ALU through add, unbias and
// optional normalize, then classifies the result. Optional macro: FP_EXP_STICKY_FLAGS_EN.
module fp_exp_sequencer
   import fp_exp_pkg::*;
#(
   parameter int EXP_WIDTH = HP_EXP_WIDTH,
   parameter int BIAS      = HP_BIAS,
   parameter int ALU_WIDTH = EXP_WIDTH + 2
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 start_in,
   input  logic [EXP_WIDTH-1:0] exp_a_in,
   input  logic [EXP_WIDTH-1:0] exp_b_in,
   input  logic                 norm_in,
   output logic                 ready_out,
   output logic [ALU_WIDTH-1:0] alu_A_out,
   output logic [ALU_WIDTH-1:0] alu_B_out,
   output logic                 alu_op_out,
   input  logic [ALU_WIDTH-1:0] alu_result_in,
   input  logic                 alu_C_in,
   output logic                 done_out,
   output logic [EXP_WIDTH-1:0] exp_out,
   output logic                 ovf_out,
   output logic                 unf_out,
   output logic                 zero_out,
   output state_t               dbg_state_out,
   output logic                 dbg_alu_c_out
`ifdef FP_EXP_STICKY_FLAGS_EN
   ,
   input  logic                 flag_clr_in,
   output logic                 sticky_ovf_out,
   output logic                 sticky_unf_out
`endif
);

   localparam int EXT_W = ALU_WIDTH - EXP_WIDTH;
   localparam logic [ALU_WIDTH-1:0] OVF_LIMIT = ALU_WIDTH'((1 << EXP_WIDTH) - 1);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [EXP_WIDTH-1:0]   r_ea;
   logic [EXP_WIDTH-1:0]   r_eb;
   logic                   r_norm;
   logic [ALU_WIDTH-1:0]   r_acc;
   logic                   r_alu_c;
   logic [EXP_WIDTH-1:0]   r_exp;
   logic                   r_ovf;
   logic                   r_unf;
   logic                   r_zero;

   logic [ALU_WIDTH-1:0]   w_alu_a;
   logic [ALU_WIDTH-1:0]   w_alu_b;
   logic                   w_alu_op;
   logic                   w_done;
   logic [EXP_WIDTH-1:0]   w_exp;
   logic                   w_ovf;
   logic                   w_unf;
   logic                   w_zero;
   logic                   w_cls_unf;
   logic                   w_cls_ovf;

   // acc is signed after unbiasing; non-positive means the exponent underflowed.
   assign w_cls_unf = r_acc[ALU_WIDTH-1] || (r_acc == '0);
   assign w_cls_ovf = !w_cls_unf && (r_acc >= OVF_LIMIT);

   always_comb begin
      w_state_nxt = r_state;
      w_alu_a     = '0;
      w_alu_b     = '0;
      w_alu_op    = ALU_OP_ADD;
      w_done      = 1'b0;
      w_exp       = r_exp;
      w_ovf       = r_ovf;
      w_unf       = r_unf;
      w_zero      = r_zero;
      case (r_state)
         IDLE: begin
            if (start_in) begin
               if (exp_a_in == '0 || exp_b_in == '0) w_state_nxt = ZERO;
               else                                  w_state_nxt = ADD;
            end
         end
         ADD: begin
            w_alu_a     = {{EXT_W{1'b0}}, r_ea};
            w_alu_b     = {{EXT_W{1'b0}}, r_eb};
            w_state_nxt = SUB;
         end
         SUB: begin
            w_alu_a     = r_acc;
            w_alu_b     = ALU_WIDTH'(BIAS);
            w_alu_op    = ALU_OP_SUB;
            w_state_nxt = r_norm ? NORM : DONE;
         end
         NORM: begin
            w_alu_a     = r_acc;
            w_alu_b     = ALU_WIDTH'(1);
            w_state_nxt = DONE;
         end
         DONE: begin
            w_done      = 1'b1;
            w_unf       = w_cls_unf;
            w_ovf       = w_cls_ovf;
            w_zero      = 1'b0;
            if (w_cls_unf)      w_exp = '0;
            else if (w_cls_ovf) w_exp = '1;
            else                w_exp = r_acc[EXP_WIDTH-1:0];
            w_state_nxt = IDLE;
         end
         ZERO: begin
            w_done      = 1'b1;
            w_zero      = 1'b1;
            w_ovf       = 1'b0;
            w_unf       = 1'b0;
            w_exp       = '0;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state <= IDLE;
         r_ea    <= '0;
         r_eb    <= '0;
         r_norm  <= 1'b0;
         r_acc   <= '0;
         r_alu_c <= 1'b0;
         r_exp   <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
         r_zero  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && start_in) begin
            r_ea   <= exp_a_in;
            r_eb   <= exp_b_in;
            r_norm <= norm_in;
         end
         if (r_state == ADD || r_state == SUB || r_state == NORM) begin
            r_acc   <= alu_result_in;
            r_alu_c <= alu_C_in;
         end
         // Results are shown combinationally in the done cycle, then held here.
         if (w_done) begin
            r_exp  <= w_exp;
            r_ovf  <= w_ovf;
            r_unf  <= w_unf;
            r_zero <= w_zero;
         end
      end
   end

`ifdef FP_EXP_STICKY_FLAGS_EN
   logic r_sticky_ovf;
   logic r_sticky_unf;

   // A flag raised in the same cycle as a clear takes priority.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_sticky_ovf <= 1'b0;
         r_sticky_unf <= 1'b0;
      end else begin
         if (w_done && w_ovf)  r_sticky_ovf <= 1'b1;
         else if (flag_clr_in) r_sticky_ovf <= 1'b0;
         if (w_done && w_unf)  r_sticky_unf <= 1'b1;
         else if (flag_clr_in) r_sticky_unf <= 1'b0;
      end
   end

   assign sticky_ovf_out = r_sticky_ovf;
   assign sticky_unf_out = r_sticky_unf;
`endif

   assign ready_out     = (r_state == IDLE);
   assign alu_A_out     = w_alu_a;
   assign alu_B_out     = w_alu_b;
   assign alu_op_out    = w_alu_op;
   assign done_out      = w_done;
   assign exp_out       = w_exp;
   assign ovf_out       = w_ovf;
   assign unf_out       = w_unf;
   assign zero_out      = w_zero;
   assign dbg_state_out = r_state;
   assign dbg_alu_c_out = r_alu_c;

endmodule

// File: doc/fp_exp_sequencer.md
Name: fp_exp_sequencer

Overview:
- Multi-cycle controller for the exponent path of the floating-point multiplier.
- Drives the external exponent add/subtract ALU (A/B operands, op select) and captures its result and flags each step.
- Step sequence: sum of biased exponents, bias removal, optional normalization increment.
- Classifies the final exponent (normal/overflow/underflow/zero operand) and hands it to the packing stage.

Parameters:
- EXP_WIDTH, 5, exponent field width (half precision).
- BIAS, 15, exponent bias subtracted after the add.
- ALU_WIDTH, EXP_WIDTH+2, ALU operand width; must equal the connected ALU's WIDTH; extra MSB serves as sign.

Ports:
- clk_in  in  1  clock.
- rst_n_in  in  1  asynchronous active-low reset.
- start_in  in  1  request; accepted only when ready_out=1.
- exp_a_in  in  EXP_WIDTH  biased exponent of operand A.
- exp_b_in  in  EXP_WIDTH  biased exponent of operand B.
- norm_in  in  1  mantissa product overflowed; add 1 to exponent.
- ready_out  out  1  high in IDLE.
- alu_A_out  out  ALU_WIDTH  ALU operand A.
- alu_B_out  out  ALU_WIDTH  ALU operand B.
- alu_op_out  out  1  0=add, 1=subtract.
- alu_result_in  in  ALU_WIDTH  ALU result.
- alu_C_in  in  1  ALU carry/borrow (unused for classification; observed for debug only).
- done_out  out  1  one-cycle pulse; result valid.
- exp_out  out  EXP_WIDTH  final exponent, held until next done.
- ovf_out, unf_out, zero_out  out  1 each  result flags, held with exp_out.

Behaviour:
- Reset, asynchronous, any state: state=IDLE; ready_out=1; done_out=0; exp_out=0; all flags=0; alu_A_out=0; alu_B_out=0; alu_op_out=0. A reset mid-operation abandons that operation and produces no done.
- IDLE, start_in=1:
  - Latch exp_a, exp_b, norm_in (zero-extended to ALU_WIDTH).
  - If either exponent == 0, go to ZERO.
  - Otherwise go to ADD.
- IDLE, start_in=0: stay in IDLE.
- start_in while not in IDLE is ignored; nothing is queued.
- ADD: drive A=ea, B=eb, op=0; at clock edge acc<=alu_result_in; go to SUB.
- SUB: drive A=acc, B=BIAS, op=1; acc<=alu_result_in; go to NORM if norm latched, else DONE.
- NORM: drive A=acc, B=1, op=0; acc<=alu_result_in; go to DONE.
- Outside ADD/SUB/NORM: alu_A_out=0, alu_B_out=0, alu_op_out=0.
- DONE: done_out=1 for this cycle; classify acc as a signed ALU_WIDTH value:
  - acc <= 0 (MSB set or all zero): unf_out=1, exp_out=0.
  - acc >= 2^EXP_WIDTH-1: ovf_out=1, exp_out=all ones.
  - Otherwise: exp_out=acc[EXP_WIDTH-1:0], ovf_out=0, unf_out=0.
  - zero_out=0. Return to IDLE.
- ZERO: done_out=1; zero_out=1; exp_out=0; ovf_out=0; unf_out=0; return to IDLE.
- Latency from the start-accept edge to the done cycle: ZERO 1 cycle; no norm 3 cycles; with norm 4 cycles.
- ready_out rises in the cycle after DONE/ZERO, so back-to-back starts are spaced by at least one IDLE cycle.
- Width: the exponent sum never exceeds 2^(EXP_WIDTH+1)-2, so no wrap occurs in ALU_WIDTH; the sign bit is valid after SUB.

Optional Feature:
- Macro: FP_EXP_STICKY_FLAGS_EN.
- Defined: adds ports flag_clr_in (in, 1) and sticky_ovf_out, sticky_unf_out (out, 1 each).
  - Sticky outputs set on any done with the matching flag and stay set until flag_clr_in=1 or reset.
  - If clear and set occur in the same cycle, set wins.
- Undefined: these ports and registers are absent; no other behaviour changes.

Decomposition:
- Package fp_exp_pkg holds:
  - the state enum (IDLE, ADD, SUB, NORM, DONE, ZERO);
  - the ALU op localparams (_add=0, _sub=1);
  - half-precision default constants.
- No sub-module: the ALU stays external so it can be shared. The bench instantiates the existing ALU and wires it to the alu_* ports.

Test Plan:
- ea=15, eb=15, norm=0 -> done 3 cycles after accept; exp_out=15; no flags set.
- ea=20, eb=10, norm=1 -> done after 4 cycles; exp_out=16; ALU op sequence add, sub, add.
- ea=30, eb=30 -> ovf_out=1; exp_out=31. Also ea=1, eb=1 -> acc=-13; unf_out=1; exp_out=0.
- ea=0, eb=25 -> done 1 cycle after accept; zero_out=1; ALU ports stay 0.
- start pulsed during SUB with new operands -> ignored; the first result is unaltered; ready_out low until after DONE.
- rst_n_in asserted low during NORM -> outputs zero immediately; no done pulse; a new start afterwards works normally.
- With FP_EXP_STICKY_FLAGS_EN defined: one overflow op then one normal op -> sticky_ovf_out stays 1. Then flag_clr_in pulsed -> sticky_ovf_out returns to 0.
